// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller: mode encodings and FSM state type.
package cpu_run_pkg;

  localparam logic [1:0] MODE_BOUNDED    = 2'd0;
  localparam logic [1:0] MODE_UNTIL_HALT = 2'd1;
  localparam logic [1:0] MODE_STEP       = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the run controller (slave) and whoever sequences it (master).
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [1:0]       mode;
  logic             step;
  logic             cpu_halt;
  logic             cpu_rst_n;
  logic             cpu_clk_en;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output start, mode, step, cpu_halt,
    input  cpu_rst_n, cpu_clk_en, running, done, timeout, cycle_cnt
  );

  modport slave (
    input  start, mode, step, cpu_halt,
    output cpu_rst_n, cpu_clk_en, running, done, timeout, cycle_cnt
  );
endinterface

// File: rtl/cpu_run_ctrl_run_counter.sv
// Saturating up-counter with synchronous clear and a look-ahead terminal-count flag.
module run_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // tc_o flags the cycle whose increment lands on term_i, so the FSM can leave on that same edge.
  assign tc_o  = (({1'b0, cnt_q} + {1'b0, CNT_ONE}) == {1'b0, term_i});
  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Sequences a CPU through a timed reset and a bounded, halt-terminated or single-stepped run.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int MAX_CYCLES = 400,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  cpu_run_ctrl_if.slave  bus
);

  if ((RST_CYCLES < 1) || (RST_CYCLES >= 2**CNT_W) ||
      (MAX_CYCLES < 1) || (MAX_CYCLES >= 2**CNT_W)) begin : g_param_check
    $fatal(1, "cpu_run_ctrl: RST_CYCLES/MAX_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] RST_TERM = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] MAX_TERM = CNT_W'(MAX_CYCLES);

  run_state_e state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       cpu_rst_n_q, cpu_rst_n_d;
  logic       cpu_clk_en_q, cpu_clk_en_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       timeout_q, timeout_d;

  logic             tmr_clr_s, tmr_en_s, tmr_tc_s;
  logic             cnt_clr_s, cnt_en_s, cnt_tc_s;
  logic [CNT_W-1:0] unused_tmr_cnt_s;
  logic [CNT_W-1:0] cycle_cnt_s;

  run_counter #(.W(CNT_W)) u_rst_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr_s),
    .en_i   (tmr_en_s),
    .term_i (RST_TERM),
    .cnt_o  (unused_tmr_cnt_s),
    .tc_o   (tmr_tc_s)
  );

  run_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .term_i (MAX_TERM),
    .cnt_o  (cycle_cnt_s),
    .tc_o   (cnt_tc_s)
  );

  // Next-state, counter control and the registered-output values derived from the next state.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    tmr_clr_s = 1'b0;
    tmr_en_s  = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d   = ST_RESET;
          mode_d    = bus.mode;
          tmr_clr_s = 1'b1;
          cnt_clr_s = 1'b1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RESET: begin
        tmr_en_s = 1'b1;
        if (tmr_tc_s) begin
          state_d = (mode_q == MODE_STEP) ? ST_STEP : ST_RUN;
        end else begin
          state_d = ST_RESET;
        end
      end
      ST_RUN: begin
        cnt_en_s = 1'b1;
        // Halt takes priority over the budget so a halt on the last cycle is not a timeout.
        if ((mode_q == MODE_UNTIL_HALT) && bus.cpu_halt) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b0;
        end else if (cnt_tc_s) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = (mode_q == MODE_UNTIL_HALT);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        cnt_en_s = cpu_clk_en_q;
        if (bus.cpu_halt) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b0;
        end else if (cpu_clk_en_q && cnt_tc_s) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_STEP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cpu_rst_n_d  = 1'b0;
    cpu_clk_en_d = 1'b0;
    running_d    = 1'b0;
    case (state_d)
      ST_RESET: begin
        cpu_clk_en_d = 1'b1;
      end
      ST_RUN: begin
        cpu_rst_n_d  = 1'b1;
        cpu_clk_en_d = 1'b1;
        running_d    = 1'b1;
      end
      ST_STEP: begin
        cpu_rst_n_d  = 1'b1;
        running_d    = 1'b1;
        cpu_clk_en_d = (state_q == ST_STEP) && bus.step;
      end
      ST_DONE: begin
        cpu_rst_n_d = 1'b1;
      end
      default: begin
        cpu_rst_n_d  = 1'b0;
        cpu_clk_en_d = 1'b0;
        running_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_BOUNDED;
      cpu_rst_n_q  <= 1'b0;
      cpu_clk_en_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      cpu_clk_en_q <= cpu_clk_en_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.cpu_clk_en = cpu_clk_en_q;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.cycle_cnt  = cycle_cnt_s;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a per-phase behavioural model checked every cycle plus literal pins.
module tb_cpu_run_ctrl;

  localparam int RST_CYCLES = 4;
  localparam int MAX_CYCLES = 400;
  localparam int CNT_W      = 16;

  localparam int PH_IDLE  = 0;
  localparam int PH_RESET = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_STEP  = 3;
  localparam int PH_DONE  = 4;

  typedef struct {
    int ph;
    int left;
    int cnt;
    int mode;
    bit done;
    bit to;
    bit en;
  } model_t;

  logic   clk;
  logic   rst;
  model_t m;
  int     n_checks;
  int     n_fail;
  int     en_run;
  int     en_rst;
  int     run_len;
  int     max_len;

  cpu_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cpu_run_ctrl #(
    .RST_CYCLES (RST_CYCLES),
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of the run-controller rules, expressed in phases and plain counts.
  function automatic model_t model_next(model_t s, logic start, logic [1:0] mode,
                                        logic step, logic halt);
    model_t n = s;
    bit granted = (s.ph == PH_STEP) && s.en;
    case (s.ph)
      PH_IDLE, PH_DONE: begin
        if (start) begin
          n.ph = PH_RESET; n.mode = int'(mode); n.left = RST_CYCLES;
          n.cnt = 0; n.done = 1'b0; n.to = 1'b0;
        end
      end
      PH_RESET: begin
        n.left = s.left - 1;
        if (n.left == 0) n.ph = (s.mode == 2) ? PH_STEP : PH_RUN;
      end
      PH_RUN: begin
        n.cnt = s.cnt + 1;
        if (s.mode == 1 && halt) begin
          n.ph = PH_DONE; n.done = 1'b1; n.to = 1'b0;
        end else if (n.cnt == MAX_CYCLES) begin
          n.ph = PH_DONE; n.done = 1'b1; n.to = (s.mode == 1);
        end
      end
      PH_STEP: begin
        if (granted) n.cnt = s.cnt + 1;
        if (halt) begin
          n.ph = PH_DONE; n.done = 1'b1; n.to = 1'b0;
        end else if (granted && n.cnt == MAX_CYCLES) begin
          n.ph = PH_DONE; n.done = 1'b1; n.to = 1'b1;
        end
      end
      default: ;
    endcase
    n.en = (n.ph == PH_RESET) || (n.ph == PH_RUN) ||
           (n.ph == PH_STEP && s.ph == PH_STEP && step);
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{default: 0};
    else     m <= model_next(m, bus.start, bus.mode, bus.step, bus.cpu_halt);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge, compare against the model and collect enable statistics.
  task automatic tick();
    @(negedge clk);
    chk("model cpu_rst_n",  int'(bus.cpu_rst_n),
        int'(m.ph == PH_RUN || m.ph == PH_STEP || m.ph == PH_DONE));
    chk("model cpu_clk_en", int'(bus.cpu_clk_en), int'(m.en));
    chk("model running",    int'(bus.running), int'(m.ph == PH_RUN || m.ph == PH_STEP));
    chk("model done",       int'(bus.done), int'(m.done));
    chk("model timeout",    int'(bus.timeout), int'(m.to));
    chk("model cycle_cnt",  int'(bus.cycle_cnt), m.cnt);
    if (bus.cpu_clk_en && bus.cpu_rst_n) begin
      en_run++;
      run_len++;
      if (run_len > max_len) max_len = run_len;
    end else begin
      run_len = 0;
      if (bus.cpu_clk_en) en_rst++;
    end
  endtask

  task automatic start_run(input logic [1:0] md);
    en_run = 0; en_rst = 0; run_len = 0; max_len = 0;
    bus.start = 1'b1;
    bus.mode  = md;
    tick();
    bus.start = 1'b0;
    bus.mode  = ~md;
    chk("restart cpu_rst_n", int'(bus.cpu_rst_n), 0);
    chk("restart clk_en",    int'(bus.cpu_clk_en), 1);
    chk("restart done",      int'(bus.done), 0);
    chk("restart timeout",   int'(bus.timeout), 0);
    chk("restart cycle_cnt", int'(bus.cycle_cnt), 0);
  endtask

  // Run until done; halt_at/start_at name an enabled-cycle number (0 = never).
  task automatic run_until_done(input int halt_at, input int start_at, input int limit);
    int i = 0;
    while (!bus.done && i < limit) begin
      bus.cpu_halt = (halt_at > 0) && bus.running && (int'(bus.cycle_cnt) == halt_at - 1);
      bus.start    = (start_at > 0) && bus.running && (int'(bus.cycle_cnt) == start_at - 1);
      if (bus.start) bus.mode = 2'd2;
      tick();
      i++;
    end
    bus.cpu_halt = 1'b0;
    bus.start    = 1'b0;
    chk("wait for done", int'(bus.done), 1);
  endtask

  task automatic wait_running(input int limit);
    int i = 0;
    while (!bus.running && i < limit) begin
      tick();
      i++;
    end
    chk("wait for running", int'(bus.running), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    en_run = 0; en_rst = 0; run_len = 0; max_len = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 2'd0; bus.step = 1'b0; bus.cpu_halt = 1'b0;
    tick();
    tick();
    chk("reset cpu_rst_n", int'(bus.cpu_rst_n), 0);
    chk("reset clk_en",    int'(bus.cpu_clk_en), 0);
    chk("reset running",   int'(bus.running), 0);
    chk("reset cycle_cnt", int'(bus.cycle_cnt), 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle clk_en", int'(bus.cpu_clk_en), 0);

    // Bounded: halt and a stray start during RUN must both be ignored.
    start_run(2'd0);
    run_until_done(50, 100, 600);
    chk("bounded reset cycles",  en_rst, RST_CYCLES);
    chk("bounded enabled cycles", en_run, 400);
    chk("bounded cycle_cnt",     int'(bus.cycle_cnt), 400);
    chk("bounded timeout",       int'(bus.timeout), 0);
    tick();
    chk("done holds clk_en low", int'(bus.cpu_clk_en), 0);

    start_run(2'd1);
    run_until_done(37, 0, 600);
    chk("halt37 cycle_cnt", int'(bus.cycle_cnt), 37);
    chk("halt37 enabled",   en_run, 37);
    chk("halt37 timeout",   int'(bus.timeout), 0);

    start_run(2'd1);
    run_until_done(0, 0, 600);
    chk("nohalt cycle_cnt", int'(bus.cycle_cnt), 400);
    chk("nohalt timeout",   int'(bus.timeout), 1);

    start_run(2'd1);
    run_until_done(400, 0, 600);
    chk("halt400 cycle_cnt", int'(bus.cycle_cnt), 400);
    chk("halt400 timeout",   int'(bus.timeout), 0);

    start_run(2'd3);
    run_until_done(10, 0, 600);
    chk("mode3 cycle_cnt", int'(bus.cycle_cnt), 400);
    chk("mode3 timeout",   int'(bus.timeout), 0);

    // Single-step: isolated pulses, then a held step, then a halt between grants.
    start_run(2'd2);
    wait_running(20);
    for (int p = 0; p < 5; p++) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      tick();
      tick();
    end
    chk("step5 grants",    en_run, 5);
    chk("step5 max burst", max_len, 1);
    chk("step5 cycle_cnt", int'(bus.cycle_cnt), 5);
    chk("step5 done",      int'(bus.done), 0);
    en_run = 0; max_len = 0;
    bus.step = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    bus.step = 1'b0;
    tick();
    tick();
    chk("held3 grants",    en_run, 3);
    chk("held3 burst",     max_len, 3);
    chk("held3 cycle_cnt", int'(bus.cycle_cnt), 8);
    bus.cpu_halt = 1'b1;
    tick();
    bus.cpu_halt = 1'b0;
    chk("step halt done",      int'(bus.done), 1);
    chk("step halt cycle_cnt", int'(bus.cycle_cnt), 8);
    chk("step halt timeout",   int'(bus.timeout), 0);

    start_run(2'd2);
    wait_running(20);
    bus.step = 1'b1;
    run_until_done(0, 0, 600);
    bus.step = 1'b0;
    chk("step budget cycle_cnt", int'(bus.cycle_cnt), 400);
    chk("step budget timeout",   int'(bus.timeout), 1);
    chk("step budget grants",    en_run, 400);

    // Asynchronous reset in the middle of a bounded run.
    start_run(2'd0);
    for (int i = 0; i < 100 && int'(bus.cycle_cnt) < 50; i++) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst cpu_rst_n", int'(bus.cpu_rst_n), 0);
    chk("async rst clk_en",    int'(bus.cpu_clk_en), 0);
    chk("async rst running",   int'(bus.running), 0);
    chk("async rst done",      int'(bus.done), 0);
    chk("async rst timeout",   int'(bus.timeout), 0);
    chk("async rst cycle_cnt", int'(bus.cycle_cnt), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("after rst idle clk_en",  int'(bus.cpu_clk_en), 0);
    chk("after rst idle rst_n",   int'(bus.cpu_rst_n), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
